// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_e     : converter FSM states
//   BCD_DIGIT_W : bits per packed BCD digit
//   ADJ_*       : double-dabble add-3 correction constants
//   min_digits  : decimal digits needed to hold any BIN_W-bit unsigned value
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned ADJ_THRESHOLD = 5;
  localparam int unsigned ADJ_OFFSET    = 3;
  localparam int unsigned BCD_MAX_DIGIT = 9;

  // ceil(bin_w * log10(2)) in fixed point, log10(2) ~= 0.30103
  function automatic int unsigned min_digits(input int unsigned bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_converter_if.sv
// Handshake bundle between the binary datapath, the converter and the BCD consumer.
//   in_valid/in_ready/bin_in    : binary word input handshake
//   out_valid/out_ready/bcd_out : packed BCD result handshake (digit 0 in [3:0])
//   busy                        : converter is in CONVERT or DONE
//   master : producer/consumer side, slave : converter side
interface bin2bcd_seq_converter_if
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
);

  logic                          in_valid;
  logic                          in_ready;
  logic [BIN_W-1:0]              bin_in;
  logic                          out_valid;
  logic                          out_ready;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
  logic                          busy;

  modport master (
    output in_valid,
    output bin_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  bcd_out,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  bin_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output bcd_out,
    output busy
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// Combinational double-dabble correction cell for one BCD digit.
//   digit_i   : current BCD digit
//   digit_c_o : digit + 3 when 5..9, unchanged when 0..4, 0 for illegal codes 10..15
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_c_o
);

  always_comb begin
    digit_c_o = digit_i;
    if (digit_i > BCD_DIGIT_W'(BCD_MAX_DIGIT)) begin
      digit_c_o = '0;
    end else if (digit_i >= BCD_DIGIT_W'(ADJ_THRESHOLD)) begin
      digit_c_o = digit_i + BCD_DIGIT_W'(ADJ_OFFSET);
    end
  end

endmodule

// File: rtl/bin2bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter, one shift-and-adjust step per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bin2bcd_seq_converter_if (input word, BCD result, busy)
module bin2bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
)(
  input  logic                     clk,
  input  logic                     rst_n,
  bin2bcd_seq_converter_if.slave   bus
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  // Elaboration-time parameter sanity
  if (BIN_W < 2) begin : g_bad_bin_w
    $error("bin2bcd_seq_converter: BIN_W must be >= 2");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
    $error("bin2bcd_seq_converter: DIGITS too small for BIN_W");
  end

  state_e           state_q,     state_d;
  logic [BIN_W-1:0] bin_q,       bin_d;
  logic [BCD_W-1:0] bcd_q,       bcd_d;
  logic [BCD_W-1:0] res_q,       res_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;

  logic [BCD_W-1:0] bcd_adj_c;

  // Add-3 correction on every digit of the working BCD register
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i   (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_c_o (bcd_adj_c[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, datapath update and registered-output decode
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    res_d   = res_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          bin_d   = bus.bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        // Adjust first, then shift: binary MSB enters BCD bit 0
        {bcd_d, bin_d} = {bcd_adj_c, bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          res_d   = bcd_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered copies of the next-state decode
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.bcd_out   = res_q;

endmodule
